// File: rtl/tlul_sram_arb_if.sv
// TL-UL type package and link interface for the SRAM arbiter.
//
// tlul_pkg holds the request (host-to-device) and response (device-to-host)
// structures of one TL-UL link. tlul_sram_arb_if bundles both directions of
// one link:
//   h2d : A-channel request fields plus d_ready
//   d2h : D-channel response fields plus a_ready
// Modports:
//   master : drives h2d, receives d2h (the host side of a link)
//   slave  : receives h2d, drives d2h (the device side of a link)
//
// Handshake semantics: a beat on a channel transfers on a rising clock edge
// where valid and ready are both high. A host holds a_valid and the A fields
// stable until a_ready is seen. The device holds D fields stable until d_ready
// is seen.

package tlul_pkg;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

interface tlul_sram_arb_if;
  tlul_pkg::tl_h2d_t h2d;
  tlul_pkg::tl_d2h_t d2h;

  modport master (output h2d, input d2h);
  modport slave  (input h2d, output d2h);
endinterface

// File: rtl/tlul_sram_arb.sv
// Two-host TL-UL arbiter in front of one single-ported SRAM TL-UL device.
//
// The core-side host has priority. After StarveLimit contested core wins the
// main-crossbar host is forced through. Accepted requests record their owner
// in an in-order routing FIFO so the in-order device responses are steered
// back to the right host. A and D paths are purely combinational.
//
// Ports:
//   clk_i          : clock
//   rst_i          : asynchronous active-high reset
//   tl_core        : core-path host link (slave side)
//   tl_main        : main-crossbar host link (slave side)
//   tl_dev         : SRAM device link (master side)
//   outstanding_o  : routing FIFO occupancy
//   busy_o         : requests pending or responses outstanding
//   protocol_err_o : sticky, set by a device D beat while nothing is outstanding

module tlul_sram_arb #(
  parameter int StarveLimit    = 4,
  parameter int MaxOutstanding = 2
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  tlul_sram_arb_if.slave                        tl_core,
  tlul_sram_arb_if.slave                        tl_main,
  tlul_sram_arb_if.master                       tl_dev,
  output logic [$clog2(MaxOutstanding+1)-1:0]   outstanding_o,
  output logic                                  busy_o,
  output logic                                  protocol_err_o
);

  localparam int CW = $clog2(MaxOutstanding + 1);
  localparam int PW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int SW = $clog2(StarveLimit + 1);

  localparam logic [CW-1:0] COUNT_FULL = CW'(MaxOutstanding);
  localparam logic [PW-1:0] PTR_LAST   = PW'(MaxOutstanding - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(StarveLimit);

  // Owner encoding used by the lock and the routing FIFO.
  localparam logic OWNER_CORE = 1'b0;
  localparam logic OWNER_MAIN = 1'b1;

  logic          lock_q;
  logic          lock_owner_q;
  logic [SW-1:0] starve_cnt_q;
  logic [CW-1:0] count_q;
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic          fifo_q [MaxOutstanding];
  logic          err_q;

  logic core_req;
  logic main_req;
  logic contested;
  logic winner;
  logic full;
  logic empty;
  logic head_owner;
  logic head_d_ready;
  logic win_a_valid;
  logic dev_a_valid;
  logic a_hs;
  logic d_pop;

  assign core_req  = tl_core.h2d.a_valid;
  assign main_req  = tl_main.h2d.a_valid;
  assign contested = core_req && main_req;

  // Fullness looks only at the registered count: a pop in this cycle does not
  // free a slot for a push in the same cycle.
  assign full  = (count_q == COUNT_FULL);
  assign empty = (count_q == '0);

  // A stalled request keeps its grant until it handshakes, so the A fields
  // seen by the device never change under a pending beat.
  always_comb begin
    winner = OWNER_CORE;
    if (lock_q) begin
      winner = lock_owner_q;
    end else if ((contested && (starve_cnt_q == STARVE_MAX)) || (main_req && !core_req)) begin
      winner = OWNER_MAIN;
    end
  end

  assign head_owner   = fifo_q[rd_ptr_q];
  assign head_d_ready = (head_owner == OWNER_MAIN) ? tl_main.h2d.d_ready : tl_core.h2d.d_ready;
  assign win_a_valid  = (winner == OWNER_MAIN) ? main_req : core_req;
  assign dev_a_valid  = win_a_valid && !full;

  assign a_hs  = dev_a_valid && tl_dev.d2h.a_ready;
  assign d_pop = tl_dev.d2h.d_valid && !empty && head_d_ready;

  // Device-side request: the winner's A fields. With nothing outstanding the
  // D channel is held ready so stray beats drain instead of wedging the device.
  always_comb begin
    tl_dev.h2d         = (winner == OWNER_MAIN) ? tl_main.h2d : tl_core.h2d;
    tl_dev.h2d.a_valid = dev_a_valid;
    tl_dev.h2d.d_ready = empty ? 1'b1 : head_d_ready;
  end

  // Host-side responses: all D fields pass through; only the FIFO head owner
  // sees d_valid, only the winner sees a_ready.
  always_comb begin
    tl_core.d2h         = tl_dev.d2h;
    tl_core.d2h.d_valid = tl_dev.d2h.d_valid && !empty && (head_owner == OWNER_CORE);
    tl_core.d2h.a_ready = tl_dev.d2h.a_ready && !full && (winner == OWNER_CORE);

    tl_main.d2h         = tl_dev.d2h;
    tl_main.d2h.d_valid = tl_dev.d2h.d_valid && !empty && (head_owner == OWNER_MAIN);
    tl_main.d2h.a_ready = tl_dev.d2h.a_ready && !full && (winner == OWNER_MAIN);
  end

  // Grant lock.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_q       <= 1'b0;
      lock_owner_q <= OWNER_CORE;
    end else if (dev_a_valid && !tl_dev.d2h.a_ready) begin
      lock_q       <= 1'b1;
      lock_owner_q <= winner;
    end else if (a_hs) begin
      lock_q       <= 1'b0;
    end
  end

  // Anti-starvation counter: counts contested core wins, cleared by any
  // main win.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_cnt_q <= '0;
    end else if (a_hs) begin
      if (winner == OWNER_MAIN) begin
        starve_cnt_q <= '0;
      end else if (contested && (starve_cnt_q != STARVE_MAX)) begin
        starve_cnt_q <= starve_cnt_q + 1'b1;
      end
    end
  end

  // Routing FIFO pointers and occupancy.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (a_hs) begin
        wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      end
      if (d_pop) begin
        rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({a_hs, d_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Owner storage; entries are only read while valid, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (a_hs) begin
      fifo_q[wr_ptr_q] <= winner;
    end
  end

  // Sticky protocol error: a D beat with nothing outstanding.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (tl_dev.d2h.d_valid && empty) begin
      err_q <= 1'b1;
    end
  end

  assign outstanding_o  = count_q;
  assign busy_o         = !empty || core_req || main_req;
  assign protocol_err_o = err_q;

endmodule

// File: tb/tb_tlul_sram_arb.sv
// Directed testbench for tlul_sram_arb (StarveLimit = 4, MaxOutstanding = 2).
// Inputs change 1 time unit after the rising edge; outputs are sampled one
// further time unit later, well away from the next edge.

module tb_tlul_sram_arb;

  localparam int StarveLimit    = 4;
  localparam int MaxOutstanding = 2;
  localparam int CW             = $clog2(MaxOutstanding + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] outstanding;
  logic          busy;
  logic          protocol_err;

  tlul_sram_arb_if core_if ();
  tlul_sram_arb_if main_if ();
  tlul_sram_arb_if dev_if ();

  tlul_sram_arb #(
    .StarveLimit    (StarveLimit),
    .MaxOutstanding (MaxOutstanding)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .tl_core        (core_if.slave),
    .tl_main        (main_if.slave),
    .tl_dev         (dev_if.master),
    .outstanding_o  (outstanding),
    .busy_o         (busy),
    .protocol_err_o (protocol_err)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] core_exp_q[$];
  logic [31:0] main_exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] resp(input logic [31:0] addr);
    return addr ^ 32'hD00D_0000;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_all();
    core_if.h2d         = '0;
    core_if.h2d.d_ready = 1'b1;
    main_if.h2d         = '0;
    main_if.h2d.d_ready = 1'b1;
    dev_if.d2h          = '0;
    dev_if.d2h.a_ready  = 1'b1;
  endtask

  task automatic core_req(input logic [31:0] addr);
    core_if.h2d.a_valid   = 1'b1;
    core_if.h2d.a_opcode  = 3'h4;
    core_if.h2d.a_size    = 2'd2;
    core_if.h2d.a_source  = 8'h0C;
    core_if.h2d.a_address = addr;
    core_if.h2d.a_mask    = 4'hF;
  endtask

  task automatic main_req(input logic [31:0] addr);
    main_if.h2d.a_valid   = 1'b1;
    main_if.h2d.a_opcode  = 3'h4;
    main_if.h2d.a_size    = 2'd2;
    main_if.h2d.a_source  = 8'h0A;
    main_if.h2d.a_address = addr;
    main_if.h2d.a_mask    = 4'hF;
  endtask

  task automatic dev_d(input logic valid, input logic [31:0] data);
    dev_if.d2h.d_valid  = valid;
    dev_if.d2h.d_opcode = 3'h1;
    dev_if.d2h.d_size   = 2'd2;
    dev_if.d2h.d_data   = data;
  endtask

  task automatic finish_report();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  endtask

  // Bound on total run time.
  initial begin
    #100000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    finish_report();
  end

  // ---------------- stimulus ----------------
  logic        prev_main;
  logic [31:0] prev_addr;
  logic        exp_main;
  logic [31:0] exp_addr;
  int          core_n;
  int          main_n;

  initial begin
    // ---- reset state ----
    rst = 1'b1;
    idle_all();
    settle();
    check("rst_outstanding", 32'(outstanding), 32'd0);
    check("rst_dev_avalid", 32'(dev_if.h2d.a_valid), 32'd0);
    check("rst_core_dvalid", 32'(core_if.d2h.d_valid), 32'd0);
    check("rst_main_dvalid", 32'(main_if.d2h.d_valid), 32'd0);
    check("rst_err", 32'(protocol_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    next_cycle();
    next_cycle();
    rst = 1'b0;
    next_cycle();

    // ---- core only: 5 back-to-back Gets, responses one cycle later ----
    for (int k = 0; k <= 5; k++) begin
      if (k < 5) core_req(32'h100 + 32'(k));
      else       core_if.h2d.a_valid = 1'b0;
      if (k > 0) dev_d(1'b1, resp(32'h100 + 32'(k - 1)));
      else       dev_d(1'b0, '0);
      settle();
      if (k < 5) begin
        check("s1_dev_avalid", 32'(dev_if.h2d.a_valid), 32'd1);
        check("s1_dev_addr", dev_if.h2d.a_address, 32'h100 + 32'(k));
        check("s1_core_aready", 32'(core_if.d2h.a_ready), 32'd1);
        check("s1_main_aready", 32'(main_if.d2h.a_ready), 32'd0);
      end
      check("s1_outstanding", 32'(outstanding), (k == 0) ? 32'd0 : 32'd1);
      check("s1_core_dvalid", 32'(core_if.d2h.d_valid), (k == 0) ? 32'd0 : 32'd1);
      check("s1_main_dvalid", 32'(main_if.d2h.d_valid), 32'd0);
      if (k > 0) check("s1_core_ddata", core_if.d2h.d_data, resp(32'h100 + 32'(k - 1)));
      next_cycle();
    end
    idle_all();
    settle();
    check("s1_outstanding_end", 32'(outstanding), 32'd0);
    check("s1_starve", 32'(dut.starve_cnt_q), 32'd0);
    next_cycle();

    // ---- contested stream: grant order C C C C M C C C C M ----
    core_n    = 0;
    main_n    = 0;
    prev_main = 1'b0;
    prev_addr = '0;
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) begin
        core_req(32'h200 + 32'(core_n));
        main_req(32'h300 + 32'(main_n));
      end else begin
        core_if.h2d.a_valid = 1'b0;
        main_if.h2d.a_valid = 1'b0;
      end
      if (i > 0) dev_d(1'b1, resp(prev_addr));
      else       dev_d(1'b0, '0);
      settle();
      exp_main = ((i % 5) == 4);
      exp_addr = exp_main ? 32'h300 + 32'(main_n) : 32'h200 + 32'(core_n);
      if (i < 10) begin
        check("s2_starve", 32'(dut.starve_cnt_q), 32'(i % 5));
        check("s2_grant_addr", dev_if.h2d.a_address, exp_addr);
        check("s2_core_aready", 32'(core_if.d2h.a_ready), exp_main ? 32'd0 : 32'd1);
        check("s2_main_aready", 32'(main_if.d2h.a_ready), exp_main ? 32'd1 : 32'd0);
      end
      if (i > 0) begin
        check("s2_core_dvalid", 32'(core_if.d2h.d_valid), prev_main ? 32'd0 : 32'd1);
        check("s2_main_dvalid", 32'(main_if.d2h.d_valid), prev_main ? 32'd1 : 32'd0);
        check("s2_ddata", prev_main ? main_if.d2h.d_data : core_if.d2h.d_data, resp(prev_addr));
      end
      if (exp_main) main_n++;
      else          core_n++;
      prev_main = exp_main;
      prev_addr = exp_addr;
      next_cycle();
    end
    idle_all();
    settle();
    check("s2_outstanding_end", 32'(outstanding), 32'd0);
    next_cycle();

    // ---- device stall: core holds the grant, main follows ----
    core_req(32'h400);
    dev_if.d2h.a_ready = 1'b0;
    settle();
    check("s3_dev_avalid", 32'(dev_if.h2d.a_valid), 32'd1);
    check("s3_addr_c0", dev_if.h2d.a_address, 32'h400);
    check("s3_core_aready_c0", 32'(core_if.d2h.a_ready), 32'd0);
    next_cycle();
    for (int c = 1; c <= 2; c++) begin
      main_req(32'h500);
      settle();
      check("s3_addr_stall", dev_if.h2d.a_address, 32'h400);
      check("s3_main_aready_stall", 32'(main_if.d2h.a_ready), 32'd0);
      next_cycle();
    end
    dev_if.d2h.a_ready = 1'b1;
    settle();
    check("s3_addr_hs", dev_if.h2d.a_address, 32'h400);
    check("s3_core_aready_hs", 32'(core_if.d2h.a_ready), 32'd1);
    check("s3_main_aready_hs", 32'(main_if.d2h.a_ready), 32'd0);
    next_cycle();
    core_if.h2d.a_valid = 1'b0;
    dev_d(1'b1, resp(32'h400));
    settle();
    check("s3_main_next_addr", dev_if.h2d.a_address, 32'h500);
    check("s3_main_next_aready", 32'(main_if.d2h.a_ready), 32'd1);
    check("s3_core_dvalid", 32'(core_if.d2h.d_valid), 32'd1);
    check("s3_core_ddata", core_if.d2h.d_data, resp(32'h400));
    next_cycle();
    main_if.h2d.a_valid = 1'b0;
    dev_d(1'b1, resp(32'h500));
    settle();
    check("s3_main_dvalid", 32'(main_if.d2h.d_valid), 32'd1);
    check("s3_core_dvalid_off", 32'(core_if.d2h.d_valid), 32'd0);
    check("s3_main_ddata", main_if.d2h.d_data, resp(32'h500));
    next_cycle();
    idle_all();
    // Main stalled first: the lock must hold it against core priority.
    main_req(32'h600);
    dev_if.d2h.a_ready = 1'b0;
    settle();
    check("s3_addr_m0", dev_if.h2d.a_address, 32'h600);
    next_cycle();
    core_req(32'h700);
    settle();
    check("s3_lock_main_addr", dev_if.h2d.a_address, 32'h600);
    check("s3_lock_core_aready", 32'(core_if.d2h.a_ready), 32'd0);
    next_cycle();
    dev_if.d2h.a_ready = 1'b1;
    settle();
    check("s3_lock_main_hs_addr", dev_if.h2d.a_address, 32'h600);
    check("s3_lock_main_aready", 32'(main_if.d2h.a_ready), 32'd1);
    check("s3_lock_core_aready_hs", 32'(core_if.d2h.a_ready), 32'd0);
    next_cycle();
    main_if.h2d.a_valid = 1'b0;
    dev_d(1'b1, resp(32'h600));
    settle();
    check("s3_core_after_addr", dev_if.h2d.a_address, 32'h700);
    check("s3_core_after_aready", 32'(core_if.d2h.a_ready), 32'd1);
    check("s3_main_dvalid2", 32'(main_if.d2h.d_valid), 32'd1);
    next_cycle();
    core_if.h2d.a_valid = 1'b0;
    dev_d(1'b1, resp(32'h700));
    settle();
    check("s3_core_dvalid2", 32'(core_if.d2h.d_valid), 32'd1);
    next_cycle();
    idle_all();
    settle();
    check("s3_outstanding_end", 32'(outstanding), 32'd0);
    next_cycle();

    // ---- FIFO full ----
    core_req(32'h800);
    settle();
    check("s4_outstanding_0", 32'(outstanding), 32'd0);
    next_cycle();
    core_if.h2d.a_valid = 1'b0;
    main_req(32'h900);
    settle();
    check("s4_main_aready_1", 32'(main_if.d2h.a_ready), 32'd1);
    next_cycle();
    core_req(32'h810);
    main_req(32'h910);
    settle();
    check("s4_outstanding_full", 32'(outstanding), 32'd2);
    check("s4_dev_avalid_full", 32'(dev_if.h2d.a_valid), 32'd0);
    check("s4_core_aready_full", 32'(core_if.d2h.a_ready), 32'd0);
    check("s4_main_aready_full", 32'(main_if.d2h.a_ready), 32'd0);
    check("s4_busy", 32'(busy), 32'd1);
    next_cycle();
    dev_d(1'b1, resp(32'h800));
    settle();
    check("s4_first_d_core", 32'(core_if.d2h.d_valid), 32'd1);
    check("s4_first_d_main", 32'(main_if.d2h.d_valid), 32'd0);
    check("s4_first_d_data", core_if.d2h.d_data, resp(32'h800));
    check("s4_no_bypass", 32'(core_if.d2h.a_ready), 32'd0);
    next_cycle();
    dev_d(1'b1, resp(32'h900));
    settle();
    check("s4_outstanding_1", 32'(outstanding), 32'd1);
    check("s4_core_aready_rise", 32'(core_if.d2h.a_ready), 32'd1);
    check("s4_main_aready_lose", 32'(main_if.d2h.a_ready), 32'd0);
    check("s4_addr_810", dev_if.h2d.a_address, 32'h810);
    check("s4_main_dvalid", 32'(main_if.d2h.d_valid), 32'd1);
    check("s4_main_ddata", main_if.d2h.d_data, resp(32'h900));
    next_cycle();
    core_if.h2d.a_valid = 1'b0;
    dev_d(1'b1, resp(32'h810));
    settle();
    check("s4_pushpop_count", 32'(outstanding), 32'd1);
    check("s4_main_aready_910", 32'(main_if.d2h.a_ready), 32'd1);
    check("s4_addr_910", dev_if.h2d.a_address, 32'h910);
    check("s4_core_dvalid_810", 32'(core_if.d2h.d_valid), 32'd1);
    next_cycle();
    main_if.h2d.a_valid = 1'b0;
    dev_d(1'b1, resp(32'h910));
    settle();
    check("s4_main_dvalid_910", 32'(main_if.d2h.d_valid), 32'd1);
    next_cycle();
    idle_all();
    settle();
    check("s4_outstanding_end", 32'(outstanding), 32'd0);
    check("s4_busy_end", 32'(busy), 32'd0);
    next_cycle();

    // ---- interleaved owners C, M, C ----
    core_req(32'hA00);
    core_exp_q.push_back(resp(32'hA00));
    settle();
    check("s5_core_aready_a00", 32'(core_if.d2h.a_ready), 32'd1);
    next_cycle();
    core_if.h2d.a_valid = 1'b0;
    main_req(32'hB00);
    main_exp_q.push_back(resp(32'hB00));
    settle();
    check("s5_main_aready_b00", 32'(main_if.d2h.a_ready), 32'd1);
    next_cycle();
    main_if.h2d.a_valid = 1'b0;
    core_req(32'hA10);
    dev_d(1'b1, resp(32'hA00));
    settle();
    check("s5_d1_core_dvalid", 32'(core_if.d2h.d_valid), 32'd1);
    check("s5_d1_core_ddata", core_if.d2h.d_data, core_exp_q.pop_front());
    check("s5_d1_core_aready", 32'(core_if.d2h.a_ready), 32'd0);
    next_cycle();
    core_exp_q.push_back(resp(32'hA10));
    dev_d(1'b1, resp(32'hB00));
    core_if.h2d.d_ready = 1'b0;
    settle();
    check("s5_d2_main_dvalid", 32'(main_if.d2h.d_valid), 32'd1);
    check("s5_d2_core_dvalid", 32'(core_if.d2h.d_valid), 32'd0);
    check("s5_d2_dev_dready", 32'(dev_if.h2d.d_ready), 32'd1);
    check("s5_d2_main_ddata", main_if.d2h.d_data, main_exp_q.pop_front());
    check("s5_d2_core_aready", 32'(core_if.d2h.a_ready), 32'd1);
    next_cycle();
    core_if.h2d.a_valid = 1'b0;
    dev_d(1'b1, resp(32'hA10));
    core_if.h2d.d_ready = 1'b0;
    main_if.h2d.d_ready = 1'b1;
    settle();
    check("s5_d3_core_dvalid", 32'(core_if.d2h.d_valid), 32'd1);
    check("s5_d3_dev_dready", 32'(dev_if.h2d.d_ready), 32'd0);
    check("s5_d3_ddata_hold", core_if.d2h.d_data, core_exp_q[0]);
    next_cycle();
    check("s5_d3_no_pop", 32'(outstanding), 32'd1);
    core_if.h2d.d_ready = 1'b1;
    main_if.h2d.d_ready = 1'b0;
    settle();
    check("s5_d4_dev_dready", 32'(dev_if.h2d.d_ready), 32'd1);
    check("s5_d4_core_dvalid", 32'(core_if.d2h.d_valid), 32'd1);
    check("s5_d4_main_dvalid", 32'(main_if.d2h.d_valid), 32'd0);
    check("s5_d4_core_ddata", core_if.d2h.d_data, core_exp_q.pop_front());
    next_cycle();
    idle_all();
    settle();
    check("s5_outstanding_end", 32'(outstanding), 32'd0);
    check("s5_core_q_empty", 32'(core_exp_q.size()), 32'd0);
    check("s5_main_q_empty", 32'(main_exp_q.size()), 32'd0);
    next_cycle();

    // ---- unsolicited D beat, then reset mid-stream ----
    dev_d(1'b1, 32'h0000_0BAD);
    settle();
    check("s6_stray_core_dvalid", 32'(core_if.d2h.d_valid), 32'd0);
    check("s6_stray_main_dvalid", 32'(main_if.d2h.d_valid), 32'd0);
    check("s6_stray_dev_dready", 32'(dev_if.h2d.d_ready), 32'd1);
    check("s6_err_before", 32'(protocol_err), 32'd0);
    next_cycle();
    dev_d(1'b0, '0);
    settle();
    check("s6_err_set", 32'(protocol_err), 32'd1);
    check("s6_outstanding_empty", 32'(outstanding), 32'd0);
    next_cycle();
    core_req(32'hC00);
    next_cycle();
    check("s6_err_sticky", 32'(protocol_err), 32'd1);
    core_if.h2d.a_valid = 1'b0;
    main_req(32'hD00);
    next_cycle();
    main_if.h2d.a_valid = 1'b0;
    settle();
    check("s6_outstanding_2", 32'(outstanding), 32'd2);
    dev_d(1'b1, resp(32'hC00));
    rst = 1'b1;
    settle();
    check("s6_rst_outstanding", 32'(outstanding), 32'd0);
    check("s6_rst_err", 32'(protocol_err), 32'd0);
    check("s6_rst_core_dvalid", 32'(core_if.d2h.d_valid), 32'd0);
    check("s6_rst_main_dvalid", 32'(main_if.d2h.d_valid), 32'd0);
    next_cycle();
    rst = 1'b0;
    next_cycle();
    dev_d(1'b0, '0);
    settle();
    check("s6_late_d_err", 32'(protocol_err), 32'd1);

    finish_report();
  end

endmodule
